csr_access_unit: RTL

CSR_ACCESS_UNIT -- requirements
Module: csr_access_unit

---
 rtl/csr_pkg.sv | 47 ++++
 rtl/csr_instr_decoder.sv | 54 +++++
 rtl/csr_access_unit.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared constants and types for the CSR access unit:
// instruction encodings, csr_op codes, CSR addresses, exception codes, FSM states.
package csr_pkg;

    localparam logic [6:0]  OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] INSTR_SRET = 32'h10200073;

    localparam logic [2:0] F3_CSRRW  = 3'b001;
    localparam logic [2:0] F3_CSRRS  = 3'b010;
    localparam logic [2:0] F3_CSRRC  = 3'b011;
    localparam logic [2:0] F3_CSRRWI = 3'b101;
    localparam logic [2:0] F3_CSRRSI = 3'b110;
    localparam logic [2:0] F3_CSRRCI = 3'b111;

    localparam logic [1:0] CSR_OP_READ  = 2'b00;
    localparam logic [1:0] CSR_OP_WRITE = 2'b01;
    localparam logic [1:0] CSR_OP_SET   = 2'b10;
    localparam logic [1:0] CSR_OP_CLEAR = 2'b11;

    localparam logic [11:0] CSR_SSTATUS  = 12'h100;
    localparam logic [11:0] CSR_SSCRATCH = 12'h140;
    localparam logic [11:0] CSR_SEPC     = 12'h141;
    localparam logic [11:0] CSR_SATP     = 12'h180;

    localparam logic [1:0] MODE_U = 2'b00;
    localparam logic [1:0] MODE_S = 2'b01;
    localparam logic [1:0] MODE_M = 2'b11;

    localparam logic [3:0] EXC_ILLEGAL_INSTR = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_WRITE,
        ST_FLUSH,
        ST_SRET,
        ST_TRAP,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        KIND_CSR,
        KIND_SRET,
        KIND_ILLEGAL
    } kind_t;

endpackage

// File: rtl/csr_instr_decoder.sv
// Combinational SYSTEM-instruction decoder: classifies CSR ops and SRET,
// and flags privilege / read-only violations as illegal.
module csr_instr_decoder
    import csr_pkg::*;
(
    input  logic [31:0] i_instr,
    input  logic [1:0]  i_mode,
    output kind_t       o_kind,
    output logic [11:0] o_csr_addr,
    output logic        o_write_needed,
    output logic        o_use_imm,
    output logic [1:0]  o_op,
    output logic        o_illegal
);

    logic [2:0] w_funct3;
    logic [4:0] w_rs1;
    logic       w_priv_fail;
    logic       w_ro_fail;

    always_comb begin
        w_funct3       = i_instr[14:12];
        w_rs1          = i_instr[19:15];
        o_kind         = KIND_ILLEGAL;
        o_write_needed = 1'b0;
        o_csr_addr     = i_instr[31:20];
        o_op           = w_funct3[1:0];
        o_use_imm      = w_funct3[2];

        if (i_instr == INSTR_SRET) begin
            o_kind = KIND_SRET;
        end else if (i_instr[6:0] == OPC_SYSTEM) begin
            unique case (w_funct3)
                F3_CSRRW, F3_CSRRWI: begin
                    o_kind         = KIND_CSR;
                    o_write_needed = 1'b1;
                end
                F3_CSRRS, F3_CSRRC, F3_CSRRSI, F3_CSRRCI: begin
                    o_kind         = KIND_CSR;
                    o_write_needed = (w_rs1 != 5'd0);
                end
                default: o_kind = KIND_ILLEGAL;
            endcase
        end

        w_priv_fail = (o_csr_addr[9:8] > i_mode);
        w_ro_fail   = o_write_needed && (o_csr_addr[11:10] == 2'b11);

        o_illegal = (o_kind == KIND_ILLEGAL)
                  | ((o_kind == KIND_SRET) && (i_mode == MODE_U))
                  | ((o_kind == KIND_CSR) && (w_priv_fail | w_ro_fail));
    end

endmodule

// File: rtl/csr_access_unit.sv
// Sequences one SYSTEM instruction at a time: CSR read / write / satp flush,
// SRET redirect or illegal-instruction trap, then a held response.
module csr_access_unit
    import csr_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [31:0]           req_instr,
    input  logic [DATA_WIDTH-1:0] req_pc,
    input  logic [DATA_WIDTH-1:0] req_rs1_data,
    input  logic                  kill,
    input  logic [1:0]            current_mode,
    output logic [11:0]           csr_addr,
    output logic [1:0]            csr_op,
    output logic [DATA_WIDTH-1:0] csr_write_data,
    input  logic [DATA_WIDTH-1:0] csr_read_data,
    input  logic                  csr_error,
    input  logic                  tlb_flush,
    output logic                  exception,
    output logic [3:0]            exception_code,
    output logic [DATA_WIDTH-1:0] exception_value,
    output logic [DATA_WIDTH-1:0] exception_pc,
    output logic [DATA_WIDTH-1:0] exception_instr,
    output logic                  return_from_exception,
    input  logic [DATA_WIDTH-1:0] return_pc,
    input  logic [1:0]            return_mode,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [4:0]            rsp_rd,
    output logic [DATA_WIDTH-1:0] rsp_rd_data,
    output logic                  rsp_rd_we,
    output logic                  rsp_trap,
    output logic                  rsp_redirect,
    output logic [DATA_WIDTH-1:0] rsp_redirect_pc,
    output logic [1:0]            rsp_mode,
    output logic                  rsp_flushed
);

    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_instr;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_rs1_data;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_old;
    logic                  r_trap;
    logic                  r_redirect;
    logic [DATA_WIDTH-1:0] r_redirect_pc;
    logic [1:0]            r_rsp_mode;
    logic                  r_flushed;

    logic                  w_accept;
    logic [31:0]           w_dec_instr;
    logic [1:0]            w_dec_mode;
    kind_t                 w_kind;
    logic [11:0]           w_csr_addr;
    logic                  w_write_needed;
    logic                  w_use_imm;
    logic [1:0]            w_op;
    logic                  w_illegal;
    logic [DATA_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH-1:0] w_instr_ext;

    // Decode the incoming request while idle, the latched one afterwards.
    assign w_accept    = req_valid && (r_state == ST_IDLE);
    assign w_dec_instr = (r_state == ST_IDLE) ? req_instr : r_instr;
    assign w_dec_mode  = (r_state == ST_IDLE) ? current_mode : r_mode;
    assign w_instr_ext = {{(DATA_WIDTH-32){1'b0}}, r_instr};
    assign w_operand   = w_use_imm
                       ? {{(DATA_WIDTH-5){1'b0}}, r_instr[19:15]}
                       : r_rs1_data;

    csr_instr_decoder u_dec (
        .i_instr        (w_dec_instr),
        .i_mode         (w_dec_mode),
        .o_kind         (w_kind),
        .o_csr_addr     (w_csr_addr),
        .o_write_needed (w_write_needed),
        .o_use_imm      (w_use_imm),
        .o_op           (w_op),
        .o_illegal      (w_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next                = r_state;
        req_ready             = 1'b0;
        csr_addr              = '0;
        csr_op                = CSR_OP_READ;
        csr_write_data        = '0;
        exception             = 1'b0;
        exception_code        = '0;
        exception_value       = '0;
        exception_pc          = '0;
        exception_instr       = '0;
        return_from_exception = 1'b0;
        rsp_valid             = 1'b0;
        rsp_rd                = '0;
        rsp_rd_data           = '0;
        rsp_rd_we             = 1'b0;
        rsp_trap              = 1'b0;
        rsp_redirect          = 1'b0;
        rsp_redirect_pc       = '0;
        rsp_mode              = '0;
        rsp_flushed           = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (w_illegal)                w_next = ST_TRAP;
                    else if (w_kind == KIND_SRET) w_next = ST_SRET;
                    else                          w_next = ST_READ;
                end
            end
            ST_READ: begin
                csr_addr = w_csr_addr;
                csr_op   = CSR_OP_READ;
                if (kill)                w_next = ST_IDLE;
                else if (csr_error)      w_next = ST_TRAP;
                else if (w_write_needed) w_next = ST_WRITE;
                else                     w_next = ST_RESP;
            end
            ST_WRITE: begin
                csr_addr       = w_csr_addr;
                csr_op         = w_op;
                csr_write_data = w_operand;
                w_next = (w_csr_addr == CSR_SATP) ? ST_FLUSH : ST_RESP;
            end
            ST_FLUSH: w_next = ST_RESP;
            ST_SRET: begin
                return_from_exception = 1'b1;
                w_next                = ST_RESP;
            end
            ST_TRAP: begin
                exception       = 1'b1;
                exception_code  = EXC_ILLEGAL_INSTR;
                exception_value = w_instr_ext;
                exception_instr = w_instr_ext;
                exception_pc    = r_pc;
                w_next          = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid       = 1'b1;
                rsp_rd          = r_instr[11:7];
                rsp_rd_data     = r_old;
                rsp_rd_we       = (r_instr[11:7] != 5'd0) & ~r_trap & ~r_redirect;
                rsp_trap        = r_trap;
                rsp_redirect    = r_redirect;
                rsp_redirect_pc = r_redirect_pc;
                rsp_mode        = r_rsp_mode;
                rsp_flushed     = r_flushed;
                if (rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr       <= '0;
            r_pc          <= '0;
            r_rs1_data    <= '0;
            r_mode        <= '0;
            r_old         <= '0;
            r_trap        <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_rsp_mode    <= '0;
            r_flushed     <= 1'b0;
        end else if (w_accept) begin
            r_instr       <= req_instr;
            r_pc          <= req_pc;
            r_rs1_data    <= req_rs1_data;
            r_mode        <= current_mode;
            r_old         <= '0;
            r_trap        <= 1'b0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_rsp_mode    <= current_mode;
            r_flushed     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_READ:  r_old     <= csr_read_data;
                ST_FLUSH: r_flushed <= tlb_flush;
                ST_SRET: begin
                    r_redirect    <= 1'b1;
                    r_redirect_pc <= return_pc;
                    r_rsp_mode    <= return_mode;
                end
                ST_TRAP:  r_trap    <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule
